alu_decode_stage: RTL
=====================

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 flush  input  1  synchronous pipeline clear.
REQ-005 in_valid  input  1  instruction word present.
REQ-006 in_instr  input  32  RV32I instruction word.
REQ-007 in_ready  output  1  block accepts in_instr this cycle.
REQ-008 out_valid  output  1  decoded bundle present.
REQ-009 out_ready  input  1  consumer (ALU issue) accepts bundle.
REQ-010 rs1_idx, rs2_idx, rd_idx  output  5 each  register indices.
REQ-011 imm  output  32  final immediate operand.
REQ-012 use_imm  output  1  select imm over rs2 value.
REQ-013 op  output  3  ALU operation (funct3 encoding).
REQ-014 mod  output  1  arithmetic-shift modifier.
REQ-015 operand_2_neg  output  1  negate operand 2 (subtract).
REQ-016 illegal  output  1  instruction not decodable by this stage.

Function
REQ-017 Transfer occurs on in_valid&&in_ready (input) and out_valid&&out_ready (output); latency from input transfer to out_valid SHALL be exactly 1 cycle.
REQ-018 Output bundle SHALL remain stable while out_valid=1 and out_ready=0.
REQ-019 OP (0110011): op=funct3, use_imm=0; funct7=0x00 -> mod=0, neg=0; funct7=0x20 with funct3=000 -> neg=1, mod=0; funct7=0x20 with funct3=101 -> mod=1, neg=0; any other funct7/funct3 combination -> illegal.
REQ-020 OP-IMM (0010011): op=funct3, use_imm=1, neg=0, rs2_idx=0; funct3 001/101 -> imm=zero-extended instr[24:20], mod=instr[30], illegal if instr[31:25] not 0x00 (or not 0x20 for 101); other funct3 -> imm=sign-extended instr[31:20], mod=0.
REQ-021 LUI (0110111): op=000, use_imm=1, rs1_idx=0, rs2_idx=0, imm={instr[31:12],12'h000}, mod=0, neg=0.
REQ-022 Any other opcode SHALL set illegal=1 with imm, op, mod, neg, use_imm, rs*_idx all 0 and rd_idx=0; illegal bundles still transfer normally.
REQ-023 flush=1 SHALL drop all held bundles (out_valid=0 next cycle) and ignore any input offered that cycle; flush takes priority over simultaneous transfers.
REQ-024 Input acceptance SHALL never overwrite an untransferred bundle.

Reset
REQ-025 While rst_n=0 on a clock edge: out_valid=0, all data outputs 0, skid storage empty; in_ready SHALL be 0 while rst_n=0.
REQ-026 Reset mid-transfer SHALL discard held bundles identically to flush; first acceptance possible the cycle after rst_n returns to 1.

Configuration
REQ-027 Macro ALU_DECODE_SKID_EN: when defined, a two-entry skid buffer SHALL be used and in_ready SHALL be a registered signal (= skid entry empty), sustaining one transfer per cycle under continuous out_ready=1.
REQ-028 When ALU_DECODE_SKID_EN is undefined, a single output register SHALL be used with in_ready = !out_valid || out_ready (combinational from out_ready), same throughput and latency.

Structure
REQ-029 Opcode constants (OP, OP-IMM, LUI), funct7 constants and ALU op codes SHALL reside in the shared ALU package also used by the ALU.
REQ-030 Pure combinational decoding SHALL be a sub-module alu_decode_comb; alu_decode_stage holds only handshake and storage.

Verification
REQ-031 0x002081B3 (ADD x3,x1,x2) -> rs1=1, rs2=2, rd=3, op=000, use_imm=0, mod=0, neg=0, illegal=0, one cycle later.
REQ-032 0x402081B3 (SUB) -> op=000, neg=1, mod=0; 0x40735293 (SRAI x5,x6,7) -> op=101, use_imm=1, imm=0x00000007, mod=1, rs1=6, rd=5.
REQ-033 0xFFF00093 (ADDI x1,x0,-1) -> imm=0xFFFFFFFF; 0x12345137 (LUI x2,0x12345) -> imm=0x12345000, rs1=0, rd=2.
REQ-034 0x00000000 and 0x0220C1B3 (funct7=0x01) -> illegal=1, all fields 0.
REQ-035 Stream 8 instructions with out_ready=0 for 3 cycles mid-stream -> no loss/duplication, bundle stable, order preserved, both macro settings.
REQ-036 flush asserted with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, flushed input never appears.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU package: RV32I opcodes, funct7 values, ALU op codes, decode bundle
package alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // ALU operations share the funct3 encoding so decode can pass funct3 straight through
    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SLL  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SR   = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [4:0]  rs1_idx;
        logic [4:0]  rs2_idx;
        logic [4:0]  rd_idx;
        logic [31:0] imm;
        logic        use_imm;
        logic [2:0]  op;
        logic        mod;
        logic        operand_2_neg;
        logic        illegal;
    } dec_bundle_t;

    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == ALU_SLL) || (funct3 == ALU_SR);
    endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// rtl/alu_decode_comb.sv - purely combinational RV32I OP/OP-IMM/LUI decode into ALU controls
module alu_decode_comb
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs1_idx,
    output logic [4:0]  rs2_idx,
    output logic [4:0]  rd_idx,
    output logic [31:0] imm,
    output logic        use_imm,
    output logic [2:0]  op,
    output logic        mod,
    output logic        operand_2_neg,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       legal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        rs1_idx       = '0;
        rs2_idx       = '0;
        rd_idx        = '0;
        imm           = '0;
        use_imm       = 1'b0;
        op            = '0;
        mod           = 1'b0;
        operand_2_neg = 1'b0;
        legal         = 1'b0;

        case (opcode)
            OPC_OP: begin
                legal = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == ALU_ADD) || (funct3 == ALU_SR)));
                rs1_idx       = instr[19:15];
                rs2_idx       = instr[24:20];
                rd_idx        = instr[11:7];
                op            = funct3;
                operand_2_neg = (funct7 == F7_ALT) && (funct3 == ALU_ADD);
                mod           = (funct7 == F7_ALT) && (funct3 == ALU_SR);
            end
            OPC_OP_IMM: begin
                rs1_idx = instr[19:15];
                rd_idx  = instr[11:7];
                op      = funct3;
                use_imm = 1'b1;
                if (is_shift(funct3)) begin
                    // shift amount lives in the rs2 field; upper bits carry the shift kind
                    imm   = {27'd0, instr[24:20]};
                    mod   = instr[30];
                    legal = (funct7 == F7_BASE) || ((funct3 == ALU_SR) && (funct7 == F7_ALT));
                end else begin
                    imm   = {{20{instr[31]}}, instr[31:20]};
                    legal = 1'b1;
                end
            end
            OPC_LUI: begin
                rd_idx  = instr[11:7];
                imm     = {instr[31:12], 12'h000};
                use_imm = 1'b1;
                legal   = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        // undecodable words leave the stage as an all-zero bundle flagged illegal
        if (!legal) begin
            rs1_idx       = '0;
            rs2_idx       = '0;
            rd_idx        = '0;
            imm           = '0;
            use_imm       = 1'b0;
            op            = '0;
            mod           = 1'b0;
            operand_2_neg = 1'b0;
        end
        illegal = !legal;
    end

endmodule

// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - decode stage handshake/storage; ALU_DECODE_SKID_EN selects a two-entry skid buffer
module alu_decode_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  rs1_idx,
    output logic [4:0]  rs2_idx,
    output logic [4:0]  rd_idx,
    output logic [31:0] imm,
    output logic        use_imm,
    output logic [2:0]  op,
    output logic        mod,
    output logic        operand_2_neg,
    output logic        illegal
);

    logic [4:0]  d_rs1_idx;
    logic [4:0]  d_rs2_idx;
    logic [4:0]  d_rd_idx;
    logic [31:0] d_imm;
    logic        d_use_imm;
    logic [2:0]  d_op;
    logic        d_mod;
    logic        d_neg;
    logic        d_illegal;

    dec_bundle_t dec;
    dec_bundle_t out_q;
    logic        out_valid_q;
    logic        in_fire;

    alu_decode_comb u_decode (
        .instr         (in_instr),
        .rs1_idx       (d_rs1_idx),
        .rs2_idx       (d_rs2_idx),
        .rd_idx        (d_rd_idx),
        .imm           (d_imm),
        .use_imm       (d_use_imm),
        .op            (d_op),
        .mod           (d_mod),
        .operand_2_neg (d_neg),
        .illegal       (d_illegal)
    );

    assign dec = '{d_rs1_idx, d_rs2_idx, d_rd_idx, d_imm, d_use_imm, d_op, d_mod, d_neg, d_illegal};

    assign in_fire = in_valid && in_ready;

`ifdef ALU_DECODE_SKID_EN
    dec_bundle_t skid_q;
    logic        skid_valid_q;

    // ready depends only on state, so the producer never sees out_ready combinationally
    assign in_ready = rst_n && !skid_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= in_fire;
                if (in_fire) begin
                    out_q <= dec;
                end
            end
        end else if (in_fire) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
        end
    end
`else
    assign in_ready = rst_n && (!out_valid_q || out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (in_fire) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid     = out_valid_q;
    assign rs1_idx       = out_q.rs1_idx;
    assign rs2_idx       = out_q.rs2_idx;
    assign rd_idx        = out_q.rd_idx;
    assign imm           = out_q.imm;
    assign use_imm       = out_q.use_imm;
    assign op            = out_q.op;
    assign mod           = out_q.mod;
    assign operand_2_neg = out_q.operand_2_neg;
    assign illegal       = out_q.illegal;

endmodule
